div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request a DIV or DIVU; sampled only in IDLE.
REQ-005 signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; latched at accept.
REQ-006 annul  in  1  flush from exception or eret; cancels the pending or in-flight divide.
REQ-007 dividend  in  32  rs operand; latched at accept.
REQ-008 divisor  in  32  rt operand; latched at accept.
REQ-009 stall  out  1  holds the pipeline while the divide is being accepted or is running.
REQ-010 valid  out  1  one-cycle strobe: hi/lo are final and the HI/LO write may proceed.
REQ-011 hi  out  32  remainder.
REQ-012 lo  out  32  quotient.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, and a 6-bit iteration counter.
REQ-014 Accept: in IDLE with start=1 and annul=0, the block SHALL latch the operands and signed_div, clear the counter and go to RUN.
REQ-015 RUN: one radix-2 restoring step per cycle on operand magnitudes; after 32 RUN cycles the FSM SHALL go to DONE.
REQ-016 DONE: lasts exactly one cycle, then the FSM SHALL return to IDLE; start SHALL be ignored in DONE.
REQ-017 Latency: start accepted at cycle T gives valid=1 at cycle T+33 and only at that cycle.
REQ-018 stall SHALL equal (IDLE & start & ~annul) | RUN; stall SHALL be 0 in DONE.
REQ-019 valid SHALL equal DONE & ~annul.
REQ-020 Sign fix-up (signed_div=1): negate the quotient iff the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-021 Magnitudes SHALL be computed in 33 bits, so 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 with no trap.
REQ-022 hi/lo SHALL keep their last result until the next DONE; a changing operand input after accept SHALL NOT affect the result.
REQ-023 annul in RUN SHALL send the FSM to IDLE on the next edge, with no valid and hi/lo unchanged.
REQ-024 annul together with start in IDLE SHALL NOT accept the request.
REQ-025 Divide by zero SHALL give the magnitudes q=0xFFFFFFFF and r=|dividend|, then the sign fix-up, giving:
- DIVU: lo=0xFFFFFFFF, hi=dividend.
- DIV, dividend>=0: lo=0xFFFFFFFF, hi=dividend.
- DIV, dividend<0: lo=0x00000001, hi=dividend.

Reset
REQ-026 While resetn=0 the block SHALL asynchronously force IDLE, counter=0, hi=0, lo=0, stall=0 and valid=0.
REQ-027 Reset during RUN SHALL abandon the operation; the first accept after reset SHALL behave as in REQ-014.

Configuration
REQ-028 Macro DIV_ZERO_FAST_EN: when defined, an accept with divisor=0 SHALL go directly to DONE with the REQ-025 result.
- valid then occurs at T+1 and stall is 1 only in the accept cycle.
REQ-029 Without DIV_ZERO_FAST_EN, a zero divisor SHALL take the full 32-iteration path with the identical REQ-025 result at T+33.

Verification
REQ-030 DIVU 100/7 accepted at T -> stall=1 for T..T+32, valid=1 at T+33 only, lo=14, hi=2.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 Accept DIVU 50/5, then annul=1 at T+10 -> stall=0 at T+11, no valid, hi/lo keep their previous values; a new start at T+11 is accepted normally.
REQ-033 DIV 0xFFFFFFF0/0 -> lo=0x00000001, hi=0xFFFFFFF0; valid at T+1 with DIV_ZERO_FAST_EN, at T+33 without.
REQ-034 resetn pulsed low at T+20 of a running divide -> state IDLE, hi=lo=0, stall=0 immediately; the next DIVU 9/4 gives lo=2, hi=1 at its T+33.
REQ-035 annul=1 in the DONE cycle -> valid stays 0, and the FSM returns to IDLE on the next edge.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU: radix-2 restoring divider, 32 RUN cycles, HI=remainder, LO=quotient.
// Define DIV_ZERO_FAST_EN to complete a divide-by-zero directly from accept in one cycle.
module div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        stall,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q, neg_r;

  logic        accept, dz;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, rem_step;
  logic [33:0] trial;
  logic [31:0] quo_step;
  logic [31:0] q_fin, r_fin;

  assign accept = (state == IDLE) & start & ~annul;
  assign dz     = (divisor == '0);

  // Magnitudes as unsigned 32-bit values: -0x80000000 maps to 0x80000000 without overflow.
  assign a_mag = (signed_div & dividend[31]) ? (32'd0 - dividend) : dividend;
  assign b_mag = (signed_div & divisor[31])  ? (32'd0 - divisor)  : divisor;

  // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    rem_sh   = 33'({rem, quo[31]});
    trial    = {1'b0, rem_sh} - {2'b00, dvs};
    rem_step = rem_sh;
    quo_step = {quo[30:0], 1'b0};
    if (!trial[33]) begin
      rem_step = 33'(trial);
      quo_step = {quo[30:0], 1'b1};
    end
    q_fin = neg_q ? (32'd0 - quo_step) : quo_step;
    r_fin = neg_r ? 32'(33'd0 - rem_step) : 32'(rem_step);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    valid     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = (FAST_DZ && dz) ? DONE : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (annul)              state_nxt = IDLE;
        else if (cnt == 6'd31)  state_nxt = DONE;
      end
      DONE: begin
        valid     = ~annul;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        rem   <= '0;
        quo   <= a_mag;
        dvs   <= b_mag;
        neg_q <= signed_div & (dividend[31] ^ divisor[31]);
        neg_r <= signed_div & dividend[31];
        if (FAST_DZ && dz) begin
          hi <= dividend;
          lo <= (signed_div & dividend[31]) ? 32'd1 : '1;
        end
      end else if (state == RUN && !annul) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt + 6'd1;
        // Result registers change only on the RUN->DONE edge, so an annulled divide leaves them intact.
        if (cnt == 6'd31) begin
          hi <= r_fin;
          lo <= q_fin;
        end
      end
    end
  end

endmodule
